// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch, load/store) arbiter in front
// of a single-port memory with a fixed read latency.
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_if_req, i_if_addr       fetch read request and byte address
//   o_if_gnt                  fetch grant (combinational, issue cycle)
//   o_if_rvalid, o_if_rdata   fetch response strobe and data
//   i_ls_req, i_ls_we,        load/store request, write enable,
//   i_ls_addr, i_ls_wdata,    address, write data, byte mask
//   i_ls_bmask
//   o_ls_gnt                  load/store grant (combinational, issue cycle)
//   o_ls_rvalid, o_ls_rdata   load/store response strobe and data
//                             (write acknowledge carries rdata = 0)
//   o_mem_en, o_mem_we,       memory command, driven only in a grant cycle
//   o_mem_addr, o_mem_wdata,
//   o_mem_bmask
//   i_mem_rdata               memory read data, valid LATENCY cycles after issue
//   o_busy                    high while a transaction is outstanding
//
// At most one transaction is in flight; each occupies LATENCY+1 cycles
// (issue cycle plus LATENCY wait cycles, the last one carrying the response).
module mem_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_ls_req,
  input  logic        i_ls_we,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [3:0]  i_ls_bmask,
  output logic        o_ls_gnt,
  output logic        o_ls_rvalid,
  output logic [31:0] o_ls_rdata,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  localparam logic [2:0] LAT3 = LATENCY[2:0];

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Requester encoding used by ptr_reg and owner_reg: 0 = fetch, 1 = load/store.
  state_t     state_reg;
  logic [2:0] cnt_reg;
  logic       ptr_reg;    // most recently granted requester
  logic       owner_reg;  // requester owning the outstanding transaction
  logic       we_reg;     // outstanding transaction is a write

  logic idle_active;
  logic pick_ls;
  logic grant_if;
  logic grant_ls;
  logic resp;

  // Outputs are forced low while reset is asserted, even in the first reset
  // cycle when the state register may still hold WAIT.
  assign idle_active = !i_reset && (state_reg == IDLE);

  // Load/store wins when it is the only requester, or when both request and
  // fetch was granted last.
  assign pick_ls  = i_ls_req && (!i_if_req || !ptr_reg);
  assign grant_ls = idle_active && pick_ls;
  assign grant_if = idle_active && i_if_req && !pick_ls;

  assign o_if_gnt = grant_if;
  assign o_ls_gnt = grant_ls;

  assign resp        = !i_reset && (state_reg == WAIT) && (cnt_reg == LAT3);
  assign o_if_rvalid = resp && !owner_reg;
  assign o_ls_rvalid = resp && owner_reg;
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : 32'd0;
  assign o_ls_rdata  = (o_ls_rvalid && !we_reg) ? i_mem_rdata : 32'd0;

  assign o_busy = !i_reset && (state_reg == WAIT);

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = 32'd0;
    o_mem_wdata = 32'd0;
    o_mem_bmask = 4'd0;
    if (grant_ls) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_ls_we;
      o_mem_addr  = i_ls_addr;
      o_mem_wdata = i_ls_wdata;
      o_mem_bmask = i_ls_bmask;
    end else if (grant_if) begin
      o_mem_en    = 1'b1;
      o_mem_addr  = i_if_addr;
      o_mem_bmask = 4'b1111;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
      ptr_reg   <= 1'b1;  // pretend load/store went last so fetch wins first
      owner_reg <= 1'b0;
      we_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_if || grant_ls) begin
            state_reg <= WAIT;
            cnt_reg   <= 3'd1;
            ptr_reg   <= grant_ls;
            owner_reg <= grant_ls;
            we_reg    <= grant_ls && i_ls_we;
          end
        end
        WAIT: begin
          if (cnt_reg == LAT3) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
          end else begin
            cnt_reg <= cnt_reg + 3'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a transaction-level reference model that
// tracks the issue cycle of the single outstanding transaction.
module tb_mem_arbiter;

  localparam int LAT = 3;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_ls_req;
  logic        i_ls_we;
  logic [31:0] i_ls_addr;
  logic [31:0] i_ls_wdata;
  logic [3:0]  i_ls_bmask;
  logic        o_ls_gnt;
  logic        o_ls_rvalid;
  logic [31:0] o_ls_rdata;
  logic        o_mem_en;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic [31:0] i_mem_rdata;
  logic        o_busy;

  mem_arbiter #(.LATENCY(LAT)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .i_ls_bmask(i_ls_bmask),
    .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
    .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a transaction is outstanding from issue_cyc+1 through
  // issue_cyc+LAT; its response appears at issue_cyc+LAT.
  int  cyc       = 0;
  bit  m_busy    = 0;
  int  issue_cyc = 0;
  bit  m_own_ls  = 0;
  bit  m_write   = 0;
  bit  m_last_ls = 1;
  int  n_if_gnt  = 0;
  int  n_ls_gnt  = 0;

  // Drives one cycle of inputs, checks every output mid-cycle, advances the
  // model and returns which requester the model expected to be granted.
  task automatic step(input logic rst,
                      input logic ifr, input logic [31:0] ifa,
                      input logic lsr, input logic lswe, input logic [31:0] lsa,
                      input logic [31:0] lsw, input logic [3:0] lsb,
                      input logic [31:0] mrd,
                      output bit g_if, output bit g_ls);
    logic        e_ifg, e_lsg, e_ifv, e_lsv, e_en, e_we, e_busy;
    logic [31:0] e_ifd, e_lsd, e_addr, e_wdata;
    logic [3:0]  e_bm;
    bit          resp_now;
    i_reset = rst; i_if_req = ifr; i_if_addr = ifa;
    i_ls_req = lsr; i_ls_we = lswe; i_ls_addr = lsa; i_ls_wdata = lsw;
    i_ls_bmask = lsb; i_mem_rdata = mrd;
    e_ifg = 0; e_lsg = 0; e_ifv = 0; e_lsv = 0; e_en = 0; e_we = 0; e_busy = 0;
    e_ifd = 0; e_lsd = 0; e_addr = 0; e_wdata = 0; e_bm = 0;
    resp_now = m_busy && (cyc == issue_cyc + LAT);
    if (!rst) begin
      if (m_busy) begin
        e_busy = 1;
        if (resp_now) begin
          if (m_own_ls) begin e_lsv = 1; e_lsd = m_write ? 32'd0 : mrd; end
          else begin e_ifv = 1; e_ifd = mrd; end
        end
      end else if (ifr || lsr) begin
        e_lsg = (ifr && lsr) ? !m_last_ls : lsr;
        e_ifg = !e_lsg;
        e_en  = 1;
        if (e_lsg) begin
          e_we = lswe; e_addr = lsa; e_wdata = lsw; e_bm = lsb;
        end else begin
          e_addr = ifa; e_bm = 4'b1111;
        end
      end
    end
    @(negedge i_clk);
    check("if_gnt", 32'(o_if_gnt), 32'(e_ifg));
    check("ls_gnt", 32'(o_ls_gnt), 32'(e_lsg));
    check("if_rvalid", 32'(o_if_rvalid), 32'(e_ifv));
    check("if_rdata", o_if_rdata, e_ifd);
    check("ls_rvalid", 32'(o_ls_rvalid), 32'(e_lsv));
    check("ls_rdata", o_ls_rdata, e_lsd);
    check("mem_en", 32'(o_mem_en), 32'(e_en));
    check("mem_we", 32'(o_mem_we), 32'(e_we));
    check("mem_addr", o_mem_addr, e_addr);
    check("mem_wdata", o_mem_wdata, e_wdata);
    check("mem_bmask", 32'(o_mem_bmask), 32'(e_bm));
    check("busy", 32'(o_busy), 32'(e_busy));
    check("one_gnt", 32'(o_if_gnt && o_ls_gnt), 32'd0);
    $display("cyc %0d rst=%0b req=%0b%0b gnt=%0b%0b rv=%0b%0b en=%0b we=%0b addr=%08h busy=%0b",
             cyc, rst, ifr, lsr, o_if_gnt, o_ls_gnt, o_if_rvalid, o_ls_rvalid,
             o_mem_en, o_mem_we, o_mem_addr, o_busy);
    g_if = e_ifg; g_ls = e_lsg;
    if (rst) begin
      m_busy = 0; m_last_ls = 1;
    end else if (m_busy) begin
      if (resp_now) m_busy = 0;
    end else if (e_ifg || e_lsg) begin
      m_busy = 1; issue_cyc = cyc; m_own_ls = e_lsg;
      m_write = e_lsg && lswe; m_last_ls = e_lsg;
      if (e_lsg) n_ls_gnt++; else n_if_gnt++;
    end
    cyc++;
    @(posedge i_clk);
    #1;
  endtask

  bit          gi, gl;
  bit          if_pend, ls_pend;
  logic [31:0] h_ifa, h_lsa, h_lsw;
  logic        h_lswe;
  logic [3:0]  h_lsb;
  int          seq_if, seq_ls;

  initial begin
    @(posedge i_clk);
    #1;
    // Reset: all outputs zero.
    for (int i = 0; i < 3; i++)
      step(1, 1, 32'h100, 1, 1, 32'h40, 32'h55, 4'hf, 32'h1234, gi, gl);

    // Fetch-only read, then the request held: next grant after LAT+1 cycles.
    step(0, 1, 32'h100, 0, 0, 0, 0, 0, 32'h0, gi, gl);
    check("dir_if_first_gnt", 32'(gi), 32'd1);
    for (int i = 0; i < LAT; i++)
      step(0, 1, 32'h100, 0, 0, 0, 0, 0, 32'h00500093, gi, gl);
    step(0, 1, 32'h104, 0, 0, 0, 0, 0, 32'h0, gi, gl);
    check("dir_if_regrant", 32'(gi), 32'd1);
    for (int i = 0; i < LAT; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 32'h13, gi, gl);

    // Store acknowledge carries zero data.
    step(0, 0, 0, 1, 1, 32'h2000, 32'hDEADBEEF, 4'b0011, 32'hFFFF0000, gi, gl);
    for (int i = 0; i < LAT; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 32'hA5A5A5A5, gi, gl);

    // Reset one cycle after issue abandons the transaction; then both request.
    step(0, 1, 32'h300, 0, 0, 0, 0, 0, 32'h0, gi, gl);
    step(1, 1, 32'h300, 1, 0, 32'h400, 0, 4'hf, 32'h77, gi, gl);
    for (int i = 0; i < LAT; i++)
      step(0, 1, 32'h300, 1, 0, 32'h400, 0, 4'hf, 32'h77, gi, gl);
    // Continuous contention: grants alternate, starting with the one after fetch.
    seq_if = n_if_gnt; seq_ls = n_ls_gnt;
    for (int i = 0; i < 4 * (LAT + 1); i++)
      step(0, 1, 32'h300, 1, 0, 32'h400, 0, 4'hf, 32'h600D0000 + 32'(i), gi, gl);
    check("alt_if_count", 32'(n_if_gnt - seq_if), 32'd2);
    check("alt_ls_count", 32'(n_ls_gnt - seq_ls), 32'd2);

    // Randomized traffic; requesters hold their command until granted.
    if_pend = 0; ls_pend = 0;
    for (int i = 0; i < 600; i++) begin
      if (!if_pend && ($urandom_range(0, 2) != 0)) begin
        if_pend = 1; h_ifa = $urandom & 32'hFFFF_FFFC;
      end
      if (!ls_pend && ($urandom_range(0, 2) != 0)) begin
        ls_pend = 1; h_lsa = $urandom; h_lsw = $urandom;
        h_lswe = 1'($urandom_range(0, 1)); h_lsb = 4'($urandom);
      end
      step(($urandom_range(0, 49) == 0), if_pend, if_pend ? h_ifa : 32'd0,
           ls_pend, ls_pend ? h_lswe : 1'b0, ls_pend ? h_lsa : 32'd0,
           ls_pend ? h_lsw : 32'd0, ls_pend ? h_lsb : 4'd0, $urandom, gi, gl);
      if (gi) if_pend = 0;
      if (gl) ls_pend = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 1, meaning the fixed number of cycles from the memory issue cycle to valid i_mem_rdata; legal range 1..7.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports i_if_req  input  1 and i_if_addr  input  32, the instruction-fetch read request and its byte address.
REQ-005 SHALL have ports o_if_gnt  output  1, o_if_rvalid  output  1 and o_if_rdata  output  32, the fetch grant, response strobe and response data.
REQ-006 SHALL have ports i_ls_req  input  1, i_ls_we  input  1, i_ls_addr  input  32, i_ls_wdata  input  32 and i_ls_bmask  input  4, the load/store request, write enable, address, write data and byte mask.
REQ-007 SHALL have ports o_ls_gnt  output  1, o_ls_rvalid  output  1 and o_ls_rdata  output  32, the load/store grant, response strobe and response data.
REQ-008 SHALL have ports o_mem_en, o_mem_we  output  1 each; o_mem_addr, o_mem_wdata  output  32 each; o_mem_bmask  output  4: the single-port memory command.
REQ-009 SHALL have port i_mem_rdata  input  32, memory read data, valid exactly LATENCY cycles after the o_mem_en cycle.
REQ-010 SHALL have port o_busy  output  1, high whenever a transaction is outstanding.

Function
REQ-011 SHALL implement FSM states IDLE and WAIT; one transaction outstanding at most.
REQ-012 In IDLE with any request high, SHALL grant exactly one requester combinationally in that cycle: o_x_gnt=1, o_mem_en=1, memory command driven from that requester's inputs; next state WAIT.
REQ-013 Fetch issues SHALL drive o_mem_we=0, o_mem_wdata=0 and o_mem_bmask=4'b1111.
REQ-014 With both requests high in IDLE, SHALL grant the requester not granted most recently (round-robin via a 1-bit pointer); with one request high, SHALL grant it regardless of the pointer.
REQ-015 The pointer SHALL update only on a grant and SHALL record the granted requester.
REQ-016 Requesters SHALL hold req and command stable until gnt; the arbiter SHALL sample the command only in the grant cycle and SHALL register the owner and the we bit.
REQ-017 In WAIT, a 3-bit counter SHALL count from 1; when it reaches LATENCY, the arbiter SHALL pulse the owner's o_x_rvalid for one cycle with o_x_rdata=i_mem_rdata and return to IDLE.
REQ-018 A write (i_ls_we=1) SHALL still produce o_ls_rvalid at issue+LATENCY as an acknowledge, with o_ls_rdata=0.
REQ-019 In WAIT, all o_x_gnt and o_mem_en SHALL be 0 and requests SHALL be ignored.
REQ-020 A new grant SHALL occur no earlier than the cycle after rvalid; per-transaction occupancy is LATENCY+1 cycles.
REQ-021 o_busy SHALL be 1 in WAIT and 0 in IDLE.
REQ-022 o_x_rdata SHALL be 0 whenever the corresponding o_x_rvalid is 0.
REQ-023 The non-owner's rvalid SHALL stay 0; at most one gnt and at most one rvalid SHALL be high in any cycle.
REQ-024 With no request in IDLE, o_mem_en=0 and all memory command outputs SHALL be 0.

Reset
REQ-025 While i_reset=1, the FSM SHALL enter IDLE, the counter SHALL clear, the pointer SHALL be set so fetch wins the first contended grant, and all gnt, rvalid, rdata, o_mem_* and o_busy outputs SHALL be 0.
REQ-026 Reset during WAIT SHALL abandon the transaction: no rvalid for it, ever.
REQ-027 A request held through reset release SHALL be granted in the first cycle after i_reset falls.

Verification
REQ-028 LATENCY=1; fetch-only request, addr 0x100, i_mem_rdata=0x00500093 at issue+1 -> o_if_gnt at T0, o_if_rvalid with o_if_rdata=0x00500093 at T1, next gnt at T2.
REQ-029 Both requesting continuously after reset -> grants alternate IF, LS, IF, LS; never two gnt high in one cycle.
REQ-030 LATENCY=3; store to 0x2000 with wdata 0xDEADBEEF and bmask 4'b0011 -> o_mem_we=1 with matching command at T0, o_ls_rvalid with rdata=0 at T3, o_busy high at T1..T3.
REQ-031 Reset asserted at issue+1 with LATENCY=3 -> no rvalid at T3, outputs 0; after release with both requesting, fetch granted first.
REQ-032 LS-only requests back-to-back at LATENCY=2 -> grants every 3 cycles; o_if_rvalid never asserts.
